muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair beside the single-cycle ALU. It accepts one operation at a time through a start/busy/done handshake and runs a shift-add multiply or a restoring divide, one bit per cycle. HI/LO update only on completion. The datapath stalls on `busy` and reads `hi`/`lo` for move-from instructions.

## Interface
- `N`, default 32: operand width; HI/LO are N bits each.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 reserved.
- `a`  in  N  multiplicand/dividend; MTHI/MTLO source.
- `b`  in  N  multiplier/divisor.
- `busy`  out  1  high in MUL, DIV, FIX and DONE states.
- `done`  out  1  one-cycle pulse; `hi`/`lo` already hold the result.
- `hi`  out  N  HI register: product[2N-1:N], or remainder.
- `lo`  out  N  LO register: product[N-1:0], or quotient.
- `div_by_zero`  out  1  set by DIV/DIVU with b==0; cleared by next accepted start.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Outputs on reset: all outputs 0; state IDLE; internal working registers 0.
- IDLE + start with MULT*/DIV*:
  - latch operands into working registers; iteration counter = N.
  - Signed ops take magnitudes and record the result signs.
  - Go to MUL or DIV.
- IDLE + start with MTHI/MTLO: write `a` to `hi`/`lo` that edge; stay IDLE; no busy, no done.
- IDLE + start with a reserved op: ignored.
- MUL: each cycle, if multiplier LSB is set, add multiplicand to the upper accumulator (N+1-bit carry kept), then shift the 2N-bit accumulator right 1. After N cycles go to FIX.
- DIV: restoring divide, one quotient bit per cycle, N cycles, then FIX.
- FIX, one cycle, for signed ops:
  - negate the 2N-bit product if signs differ;
  - negate the quotient if dividend sign ≠ divisor sign;
  - give the remainder the sign of the dividend.
  - Write `hi`/`lo` at the end of FIX, then go to DONE.
- DIV*/b==0: skip iteration and go straight to DONE. Write `hi`=a, `lo`=all ones, set `div_by_zero`.
- DONE: `done`=1 for one cycle, then IDLE.
- Signed overflow case, DIV 0x80000000 / 0xFFFFFFFF (N=32): `lo`=0x80000000, `hi`=0, no flag.
- `hi`/`lo` hold their previous values throughout MUL/DIV.
- `start` while busy is ignored, with no queuing.

## Timing
- Start accepted at edge 0: MUL/DIV cycles 1..N, FIX cycle N+1, `done` high in cycle N+2, `hi`/`lo` valid from cycle N+2.
- IDLE again at cycle N+3; a new start is accepted at the edge ending cycle N+3 or later.
- Divide-by-zero: `done` high in cycle 1, `hi`/`lo`/`div_by_zero` valid in cycle 1.
- `rst_n` low mid-operation: all outputs 0 immediately (asynchronous); the operation is lost.

## Configuration
- `MULDIV_SIGNED_EN` defined: MULT/DIV use signed magnitude handling and FIX sign correction as above.
- `MULDIV_SIGNED_EN` undefined:
  - MULT behaves exactly as MULTU; DIV behaves exactly as DIVU.
  - FIX still takes one cycle, so latency is unchanged.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` at cycle 34, `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high cycles 1–34.
- MULT a=0xFFFFFFFD (−3), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Without `MULDIV_SIGNED_EN`: `hi`=0x00000006, `lo`=0xFFFFFFEB.
- DIVU a=100, b=7 → `lo`=14, `hi`=2. DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=0x1234, b=0 → `done` at cycle 1, `hi`=0x1234, `lo`=0xFFFFFFFF, `div_by_zero`=1. Next MULTU 2×3 start clears the flag; `lo`=6.
- MULTU 5×6 started, then start with DIVU 9/3 at cycle 5 → ignored; `lo`=30 at cycle 34. MTHI a=0xABCD in IDLE → `hi`=0xABCD next cycle, `done` stays 0.
- `rst_n` low at cycle 10 of a MULTU → `busy`/`done`/`hi`/`lo` go to 0 without a clock edge. After release, MULTU 3×4 → `lo`=12.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO; shift-add multiply, restoring divide, one bit per cycle.
// Latency: done in cycle N+2 after the accepting edge (cycle 1 for divide-by-zero); MTHI/MTLO write on the accepting edge.
// Backpressure: start is sampled only in IDLE; starts while busy are dropped. Signed MULT/DIV need `MULDIV_SIGNED_EN.
module muldiv_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state;
    logic [2*N-1:0]  acc;
    logic [N-1:0]    opnd;
    logic [CW-1:0]   cnt;
    logic            neg_res;
    logic            neg_rem;
    logic            is_div;

    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;
    logic [N:0]      mul_sum;
    logic [N:0]      div_shift;
    logic [N:0]      div_diff;
    logic [2*N-1:0]  prod_fix;
    logic [N-1:0]    quo_fix;
    logic [N-1:0]    rem_fix;

    always_comb begin
`ifdef MULDIV_SIGNED_EN
        signed_op = op[0];
`else
        signed_op = 1'b0;
`endif
        a_neg = signed_op & a[N-1];
        b_neg = signed_op & b[N-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // Multiply keeps the carry out of the upper half; divide trials the shifted partial remainder.
    always_comb begin
        mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
        div_shift = {acc[2*N-1:N], acc[N-1]};
        div_diff  = div_shift - {1'b0, opnd};
        prod_fix  = neg_res ? -acc : acc;
        quo_fix   = neg_res ? -acc[N-1:0] : acc[N-1:0];
        rem_fix   = neg_rem ? -acc[2*N-1:N] : acc[2*N-1:N];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc         <= '0;
            opnd        <= '0;
            cnt         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            is_div      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'b000, 3'b001: begin
                                acc         <= {{N{1'b0}}, b_mag};
                                opnd        <= a_mag;
                                neg_res     <= a_neg ^ b_neg;
                                neg_rem     <= 1'b0;
                                is_div      <= 1'b0;
                                cnt         <= CW'(N);
                                busy        <= 1'b1;
                                div_by_zero <= 1'b0;
                                state       <= S_MUL;
                            end
                            3'b010, 3'b011: begin
                                busy <= 1'b1;
                                if (b == '0) begin
                                    hi          <= a;
                                    lo          <= '1;
                                    div_by_zero <= 1'b1;
                                    done        <= 1'b1;
                                    state       <= S_DONE;
                                end else begin
                                    acc         <= {{N{1'b0}}, a_mag};
                                    opnd        <= b_mag;
                                    neg_res     <= a_neg ^ b_neg;
                                    neg_rem     <= a_neg;
                                    is_div      <= 1'b1;
                                    cnt         <= CW'(N);
                                    div_by_zero <= 1'b0;
                                    state       <= S_DIV;
                                end
                            end
                            3'b100: begin
                                hi          <= a;
                                div_by_zero <= 1'b0;
                            end
                            3'b101: begin
                                lo          <= a;
                                div_by_zero <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[N-1:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_DIV: begin
                    if (!div_diff[N]) acc <= {div_diff[N-1:0], acc[N-2:0], 1'b1};
                    else              acc <= {div_shift[N-1:0], acc[N-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*N-1:N];
                        lo <= prod_fix[N-1:0];
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq (N=32); expectations follow `MULDIV_SIGNED_EN.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_vec = 0;
    int n_bad = 0;

    muldiv_seq #(.N(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents a start for one cycle; returns at the falling edge of cycle 1.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc, output bit busy_gap);
        cyc = c0;
        busy_gap = 1'b0;
        while (!done && cyc < 100) begin
            if (!busy) busy_gap = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (!busy) busy_gap = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        bit gap;
        issue(o, x, y);
        wait_done(1, cyc, gap);
        chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int cyc;
        bit gap;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULTU full-scale: latency and busy window
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, cyc, gap);
        chk("multu_cyc", 64'(cyc), 64'd34);
        chk("multu_busy_gap", 64'(gap), 64'd0);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);
        @(negedge clk);
        chk("multu_busy_after", 64'(busy), 64'd0);
        chk("multu_done_pulse", 64'(done), 64'd0);

`ifdef MULDIV_SIGNED_EN
        run_op("mult", 3'b001, 32'hFFFF_FFFD, 32'd7, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);
        run_op("div_pos_neg", 3'b011, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD);
`else
        run_op("mult", 3'b001, 32'hFFFF_FFFD, 32'd7, 34, 32'h0000_0006, 32'hFFFF_FFEB);
        run_op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 34, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'h0);
`endif
        chk("div_ovf_dbz", 64'(div_by_zero), 64'd0);
        run_op("divu", 3'b010, 32'd100, 32'd7, 34, 32'd2, 32'd14);

        // divide by zero short path
        run_op("dbz", 3'b010, 32'h1234, 32'd0, 1, 32'h1234, 32'hFFFF_FFFF);
        chk("dbz_flag", 64'(div_by_zero), 64'd1);
        issue(3'b000, 32'd2, 32'd3);
        chk("dbz_clear", 64'(div_by_zero), 64'd0);
        wait_done(1, cyc, gap);
        chk("mul23_lo", 64'(lo), 64'd6);

        // start while busy is dropped
        issue(3'b000, 32'd5, 32'd6);
        repeat (4) @(negedge clk);
        op = 3'b010; a = 32'd9; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, cyc, gap);
        chk("ign_cyc", 64'(cyc), 64'd34);
        chk("ign_hi", 64'(hi), 64'd0);
        chk("ign_lo", 64'(lo), 64'd30);
        repeat (2) @(negedge clk);
        chk("ign_no_redo", 64'({busy, done}), 64'd0);

        // MTHI / MTLO / reserved op
        issue(3'b100, 32'hABCD, 32'd0);
        chk("mthi_hi", 64'(hi), 64'hABCD);
        chk("mthi_done", 64'(done), 64'd0);
        chk("mthi_busy", 64'(busy), 64'd0);
        issue(3'b101, 32'h5A5A, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'h5A5A);
        issue(3'b110, 32'h1111, 32'h2222);
        chk("rsv_state", 64'({busy, hi, lo}), {31'd0, 1'b0, 32'hABCD, 32'h5A5A});

        // asynchronous reset mid-multiply
        issue(3'b000, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 3'b000, 32'd3, 32'd4, 34, 32'd0, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
